// File: rtl/picorv_stream_bridge_pkg.sv
// Shared constants, FSM state type and STATUS layout for the picorv stream bridge.
package picorv_stream_pkg;

  localparam int RX_OFS    = 4;
  localparam int TX_OFS    = 8;
  localparam int CH_STRIDE = 8;
  localparam logic [11:0] STATUS_OFS = 12'h100;

  localparam int ST_NE_LSB   = 0;
  localparam int ST_FULL_LSB = 8;
  localparam int ST_RDY_LSB  = 16;
  localparam int ST_TMO_BIT  = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RX_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } state_e;

  // Region offset of a per-channel register.
  function automatic logic [11:0] chan_ofs(input int base, input int k);
    return 12'(base + CH_STRIDE * k);
  endfunction

endpackage

// File: rtl/picorv_stream_bridge_if.sv
// picorv32 native memory bus as seen by the stream bridge (CPU = master).
interface picorv_stream_bridge_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mmio_sel;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, mmio_sel
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, mmio_sel
  );
endinterface

// File: rtl/picorv_stream_bridge_stream_fifo.sv
// Synchronous FIFO with show-ahead head word; one instance buffers each RX channel.
module stream_fifo #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DWIDTH-1:0]        din,
  output logic [DWIDTH-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/picorv_stream_bridge.sv
// MMIO bridge mapping NUM_CH RX/TX word streams plus STATUS into a 4 KiB picorv32 region.
// Optional RX empty-read timeout is enabled by defining PICORV_STREAM_RX_TIMEOUT_EN.
module picorv_stream_bridge
  import picorv_stream_pkg::*;
#(
  parameter int          NUM_CH         = 4,
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  picorv_stream_bridge_if.slave bus,
  input  logic [NUM_CH*32-1:0]  din,
  input  logic [NUM_CH-1:0]     val_in,
  output logic [NUM_CH-1:0]     ready_upward,
  output logic [NUM_CH*32-1:0]  dout,
  output logic [NUM_CH-1:0]     val_out,
  input  logic [NUM_CH-1:0]     ready_downward,
  output logic [NUM_CH-1:0]     rx_irq
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q;
  logic [CHW-1:0]    ch_q;
  logic              mem_ready_q;
  logic [31:0]       mem_rdata_q;
  logic [NUM_CH-1:0] rx_irq_q;
  logic              tmo_flag;

  logic              req, wr, status_hit, rx_any, tx_any;
  logic [CHW-1:0]    rx_sel, tx_sel;
  logic [NUM_CH-1:0] tx_hit;
  logic [31:0]       status_word;

  logic [NUM_CH-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_nonzero;
  logic [31:0]       fifo_head [NUM_CH];
  logic [FCW-1:0]    fifo_count [NUM_CH];

  assign bus.mmio_sel  = (bus.mem_addr[31:12] == BASE_ADDR[31:12]);
  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign wr            = |bus.mem_wstrb;
  assign req           = bus.mem_valid && bus.mmio_sel && !mem_ready_q && (state_q == ST_IDLE);
  assign status_hit    = (bus.mem_addr[11:0] == STATUS_OFS);
  assign ready_upward  = ~fifo_full;
  assign fifo_push     = val_in & ~fifo_full;
  assign val_out       = req ? tx_hit : '0;
  assign rx_irq        = rx_irq_q;
  assign dout          = {NUM_CH{bus.mem_wdata}};

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      stream_fifo #(.DWIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push[g]),
        .pop   (fifo_pop[g]),
        .din   (din[32*g +: 32]),
        .dout  (fifo_head[g]),
        .full  (fifo_full[g]),
        .empty (fifo_empty[g]),
        .count (fifo_count[g])
      );
      assign fifo_nonzero[g] = (fifo_count[g] != '0);
    end
  endgenerate

  // Address decode: RX data is read-only, TX data is write-only.
  always_comb begin
    rx_any = 1'b0;
    tx_any = 1'b0;
    rx_sel = '0;
    tx_sel = '0;
    tx_hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!wr && bus.mem_addr[11:0] == chan_ofs(RX_OFS, k)) begin
        rx_any = 1'b1;
        rx_sel = CHW'(k);
      end else if (wr && bus.mem_addr[11:0] == chan_ofs(TX_OFS, k)) begin
        tx_any    = 1'b1;
        tx_sel    = CHW'(k);
        tx_hit[k] = 1'b1;
      end else begin
        tx_hit[k] = 1'b0;
      end
    end
  end

  always_comb begin
    status_word                             = '0;
    status_word[ST_NE_LSB   +: NUM_CH]      = ~fifo_empty;
    status_word[ST_FULL_LSB +: NUM_CH]      = fifo_full;
    status_word[ST_RDY_LSB  +: NUM_CH]      = ready_downward;
    status_word[ST_TMO_BIT]                 = tmo_flag;
  end

  always_comb begin
    fifo_pop = '0;
    if (req && rx_any && !fifo_empty[rx_sel]) begin
      fifo_pop[rx_sel] = 1'b1;
    end else if (state_q == ST_RX_WAIT && !fifo_empty[ch_q]) begin
      fifo_pop[ch_q] = 1'b1;
    end else begin
      fifo_pop = '0;
    end
  end

`ifdef PICORV_STREAM_RX_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  logic [TCW-1:0] tmo_cnt_q;
  logic           tmo_q;
  assign tmo_flag = tmo_q;
`else
  assign tmo_flag = 1'b0;
`endif

  // Bus FSM; the timeout count includes the request cycle so expiry lands TIMEOUT_CYCLES after mem_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      rx_irq_q    <= '0;
`ifdef PICORV_STREAM_RX_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      rx_irq_q <= fifo_nonzero;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (rx_any) begin
              ch_q <= rx_sel;
              if (!fifo_empty[rx_sel]) begin
                mem_rdata_q <= fifo_head[rx_sel];
                mem_ready_q <= 1'b1;
                state_q     <= ST_RESP;
              end else begin
                state_q <= ST_RX_WAIT;
`ifdef PICORV_STREAM_RX_TIMEOUT_EN
                tmo_cnt_q <= TCW'(1);
`endif
              end
            end else if (tx_any) begin
              if (ready_downward[tx_sel]) begin
                mem_rdata_q <= '0;
                mem_ready_q <= 1'b1;
                state_q     <= ST_RESP;
              end
            end else begin
              mem_rdata_q <= (status_hit && !wr) ? status_word : 32'h0000_0000;
              mem_ready_q <= 1'b1;
              state_q     <= ST_RESP;
`ifdef PICORV_STREAM_RX_TIMEOUT_EN
              if (status_hit && wr) tmo_q <= 1'b0;
`endif
            end
          end
        end
        ST_RX_WAIT: begin
          if (!fifo_empty[ch_q]) begin
            mem_rdata_q <= fifo_head[ch_q];
            mem_ready_q <= 1'b1;
            state_q     <= ST_RESP;
`ifdef PICORV_STREAM_RX_TIMEOUT_EN
          end else if (tmo_cnt_q >= TCW'(TIMEOUT_CYCLES - 1)) begin
            mem_rdata_q <= 32'hFFFF_FFFF;
            mem_ready_q <= 1'b1;
            tmo_q       <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TCW'(1);
`endif
          end
        end
        ST_RESP: begin
          mem_ready_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          mem_ready_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/picorv_stream_bridge.md
Name: picorv_stream_bridge

Overview:
- Parametrised MMIO stream bridge for the picorv32 native memory bus. Maps NUM_CH bidirectional 32-bit valid/ready stream channels into a 4 KiB region at BASE_ADDR.
- Next-generation stream path for picorv_mem-style wrappers: each RX channel is buffered in a FIFO instead of a read-counter handshake, and the block adds a status register and per-channel RX interrupts.
- The parent muxes mem_ready/mem_rdata with RAM using mmio_sel.

Parameters:
- NUM_CH, 4, channel count, 1..8
- FIFO_DEPTH, 4, RX FIFO entries per channel, power of two, ≥2
- BASE_ADDR, 32'h10000000, region base, 4 KiB aligned
- TIMEOUT_CYCLES, 1024, RX empty-read timeout; used only with RX_TIMEOUT_EN

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- mem_valid  in  1  CPU request
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 = read
- mem_ready  out  1  one-cycle response pulse, registered
- mem_rdata  out  32  response data, registered
- mmio_sel  out  1  comb.: mem_addr[31:12]==BASE_ADDR[31:12]
- din  in  NUM_CH*32  RX data, channel k at [32k+31:32k]
- val_in  in  NUM_CH  RX valid
- ready_upward  out  NUM_CH  RX ready = !full[k]
- dout  out  NUM_CH*32  TX data; every slice = mem_wdata
- val_out  out  NUM_CH  TX valid
- ready_downward  in  NUM_CH  TX ready
- rx_irq  out  NUM_CH  level: RX FIFO k non-empty, registered

Behaviour:
- Reset: FIFOs emptied, FSM→IDLE, mem_ready=0, mem_rdata=0, val_out=0, rx_irq=0, timeout flag=0. An in-flight transaction is abandoned.
- Address map, offset from BASE_ADDR, channel k<NUM_CH:
  - RX data read: 8k+4
  - TX data write: 8k+8
  - STATUS: 0x100
- STATUS fields:
  - [7:0] RX non-empty
  - [15:8] RX full
  - [23:16] ready_downward
  - [31] timeout sticky
  - Unused bits read 0. A write to STATUS clears bit 31.
- Any other in-region access, including RX-write, TX-read and k≥NUM_CH: mem_ready one cycle after mem_valid, rdata 0, no side effect.
- Out of region: the block never asserts mem_ready and has no side effects.
- Request accepted when mem_valid && mmio_sel && !mem_ready && FSM==IDLE. The cycle in which mem_ready=1 is never a new request.
- RX read, FIFO non-empty at cycle t:
  - Pop at t.
  - mem_rdata=head and mem_ready=1 at t+1.
- RX read, FIFO empty: FSM→RX_WAIT, poll each cycle, pop on the first non-empty cycle, respond the next cycle.
- TX write:
  - val_out[k]=mem_valid && addr hit && !mem_ready && |mem_wstrb (combinational).
  - Transfer occurs in the cycle val_out[k] && ready_downward[k]; mem_ready=1 the following cycle.
  - val_out drops in the mem_ready cycle, so exactly one transfer per store.
  - Byte strobes are ignored; the full word is sent.
- FSM states: IDLE, RX_WAIT, RESP.
  - RESP lasts one cycle with mem_ready=1, then →IDLE.
  - TX and non-stalling accesses go IDLE→RESP.
- FIFO rules:
  - Push when val_in && ready_upward.
  - When full, ready_upward=0 even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- Channels are independent; RX pushes continue while the CPU stalls on another channel.

Optional Feature:
- Macro: PICORV_STREAM_RX_TIMEOUT_EN.
- Defined: RX_WAIT counts cycles. At TIMEOUT_CYCLES with the FIFO still empty, respond with mem_rdata=32'hFFFFFFFF, set STATUS[31], no pop. A pop in the same cycle as expiry wins.
- Undefined: RX_WAIT stalls indefinitely; STATUS[31] reads 0.

Decomposition:
- Package picorv_stream_pkg:
  - Offsets RX_OFS=4, TX_OFS=8, CH_STRIDE=8, STATUS_OFS=12'h100
  - FSM state enum
  - STATUS bit positions
- Sub-module stream_fifo: synchronous FIFO, params DWIDTH/DEPTH; ports push, pop, din, dout, full, empty, count. Instantiated once per channel via generate.

Test Plan:
- Reset→FIFO fill: val_in[0]=1 with din 0xA0..0xA3, FIFO_DEPTH=4 → ready_upward[0]=0 after 4 pushes; STATUS read returns 0x00010101 (ready_downward[0]=1, others 0).
- RX ordered read: after the fill, 4 loads from 0x10000004 → 0xA0,0xA1,0xA2,0xA3, each mem_ready exactly one cycle after mem_valid; rx_irq[0] falls after the last pop.
- RX stall: load 0x1000000C with channel 1 empty, push 0x55 ten cycles later → mem_ready on push cycle+2, rdata 0x55.
- TX backpressure: store 0xDEADBEEF to 0x10000010 with ready_downward[1]=0 for 5 cycles, then 1 → val_out[1] high 6 cycles, one transfer, mem_ready the next cycle.
- Unmapped/out-of-region: load 0x10000040 (NUM_CH=4) → rdata 0 in 1 cycle; load 0x20000000 → mmio_sel=0, mem_ready never asserted.
- Timeout (macro defined, TIMEOUT_CYCLES=16): load an empty RX → rdata 0xFFFFFFFF after 16 cycles, STATUS[31]=1; store to 0x10000100 → STATUS[31]=0.
